wbxbc_req_slice: RTL and testbench
==================================

WBXBC_REQ_SLICE -- requirements
Module: wbxbc_req_slice

Interface
REQ-001 Parameters SHALL be, one per line: ADR_WIDTH, 16, address width; DAT_WIDTH, 16, data width; SEL_WIDTH, 2, select lines; TGA_WIDTH, 1, address tags; TGC_WIDTH, 1, cycle tags; TGWD_WIDTH, 1, write data tags; TGRD_WIDTH, 1, read data tags; CNT_WIDTH, 3, outstanding counter width.
REQ-002 Ports SHALL be, one per line, in the following order.
- clk_i  in  1  module clock; one clock.
- async_rst_i  in  1  reset, asynchronous, active-high.
- sync_rst_i  in  1  synchronous clear, active-high.
- itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i  in  1 each  initiator request controls.
- itr_sel_i/adr_i/dat_i/tga_i/tgc_i/tgd_i  in  SEL/ADR/DAT/TGA/TGC/TGWD_WIDTH  request payload.
- itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o  out  1 each  responses to initiator.
- itr_dat_o, itr_tgd_o  out  DAT/TGRD_WIDTH  read data and tags.
- tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o  out  1 each  target request controls.
- tgt_sel_o/adr_o/dat_o/tga_o/tgc_o/tgd_o  out  matching widths  registered payload.
- tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each  target responses.
- tgt_dat_i, tgt_tgd_i  in  DAT/TGRD_WIDTH  read data and tags.
- tb_busy  out  1  outstanding count nonzero or a buffer entry valid.

Function
REQ-003 The block SHALL insert one register stage in the pipelined Wishbone request path; the response path SHALL be combinational.
REQ-004 Storage SHALL be a 2-entry skid buffer: output entry (OUT) driving tgt_* payload, and skid entry (SKD).
REQ-005 The initiator accept condition SHALL be itr_cyc_i & itr_stb_i & ~itr_stall_o.
REQ-006 The target issue condition SHALL be tgt_stb_o & ~tgt_stall_i.
REQ-007 itr_stall_o SHALL be registered and SHALL equal SKD valid.
REQ-008 On accept: if OUT is empty or is issuing, the request SHALL load OUT; otherwise it SHALL load SKD.
REQ-009 On issue with SKD valid, SKD SHALL move to OUT and SKD SHALL clear.
REQ-010 Request latency SHALL be 1 cycle (accept at edge N, tgt_stb_o high after edge N).
REQ-011 Order SHALL be preserved; there SHALL be no loss or duplication.
REQ-012 tgt_stb_o SHALL equal OUT valid & itr_cyc_i & ~cnt_full.
- cnt_full means the outstanding counter equals 2^CNT_WIDTH-1.
REQ-013 tgt_cyc_o SHALL equal itr_cyc_i; tgt_lock_o SHALL equal itr_lock_i & itr_cyc_i.
REQ-014 When itr_cyc_i is low at a clock edge, OUT, SKD and the counter SHALL clear (abort).
REQ-015 Outstanding counter operation:
- +1 on issue; -1 on a counted response (tgt_ack_i|tgt_err_i|tgt_rty_i).
- Unchanged on simultaneous issue and response.
- No wrap at either end; a response at zero count SHALL leave the counter at 0.
REQ-016 itr_ack_o/err_o/rty_o SHALL equal tgt_ack_i/err_i/rty_i gated by itr_cyc_i; itr_dat_o and itr_tgd_o SHALL equal tgt_dat_i and tgt_tgd_i.
REQ-017 Payload registers SHALL load only on entry load; they SHALL hold otherwise.

Reset
REQ-018 On async_rst_i, or on sync_rst_i at a clock edge, the block SHALL clear OUT valid, SKD valid, counter and itr_stall_o.
REQ-019 During reset, tgt_stb_o and tb_busy SHALL be 0; payload register values SHALL be don't-care.
REQ-020 A reset asserted mid-operation SHALL discard buffered requests; responses SHALL still pass combinationally.

Configuration
REQ-021 Macro WBXBC_REQ_SLICE_RSP_FILTER_EN SHALL control response filtering.
- Defined: target responses arriving while the counter is 0 and no issue occurs in that cycle SHALL be suppressed (itr_ack_o/err_o/rty_o held 0).
- Undefined: responses SHALL pass unconditionally per REQ-016.

Verification
REQ-022 Single write, tgt_stall_i=0, adr 0x1234, dat 0xBEEF -> tgt_stb_o high 1 cycle later with identical payload; tgt_ack_i -> itr_ack_o same cycle; counter back to 0.
REQ-023 Three back-to-back reads with tgt_stall_i held high 3 cycles -> itr_stall_o rises after the second accept; all three issued in order A0, A1, A2 once stall releases; no drop.
REQ-024 CNT_WIDTH=2, target never acks -> after 3 issues tgt_stb_o=0 with OUT valid; one ack -> fourth request issues the next cycle.
REQ-025 itr_cyc_i dropped with OUT and SKD valid -> both cleared next edge; tgt_stb_o=0; itr_stall_o=0; counter=0.
REQ-026 Stray tgt_ack_i with counter 0 -> itr_ack_o=0 with macro defined, itr_ack_o=1 without it; async_rst_i pulsed mid-burst -> tb_busy=0 immediately.

Source files
------------

// File: rtl/wbxbc_req_slice.sv
// wbxbc_req_slice
//   Pipelined Wishbone request register slice. Requests pass through a
//   2-entry skid buffer: OUT drives the tgt_* payload and SKD catches one
//   request while OUT is blocked. Responses pass straight back
//   combinationally. An outstanding counter tracks issued requests that
//   have not yet been answered, and it throttles issue when it saturates.
//
//   Optional macro: WBXBC_REQ_SLICE_RSP_FILTER_EN. When defined, target
//   responses that arrive with no outstanding request (and no issue in the
//   same cycle) are blocked and do not reach the initiator.
//
// Ports
//   clk_i, async_rst_i, sync_rst_i     clock, async reset, sync clear (active-high)
//   itr_* inputs                       initiator request controls and payload
//   itr_ack/err/rty/stall_o, dat/tgd   responses to the initiator
//   tgt_* outputs                      registered request toward the target
//   tgt_ack/err/rty/stall_i, dat/tgd   target responses
//   tb_busy                            outstanding count nonzero or an entry valid
module wbxbc_req_slice #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i,
  output logic                  tb_busy
);

  typedef struct packed {
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [ADR_WIDTH-1:0]  adr;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGA_WIDTH-1:0]  tga;
    logic [TGC_WIDTH-1:0]  tgc;
    logic [TGWD_WIDTH-1:0] tgd;
  } req_t;

  req_t                 in_req, out_req, skd_req;
  logic                 out_vld, skd_vld;
  logic                 out_vld_nxt, skd_vld_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 any_rst, cnt_full, accept, issue, rsp, rsp_pass;
  logic                 out_load_in, out_load_skd, skd_load;

  assign in_req = '{we: itr_we_i, sel: itr_sel_i, adr: itr_adr_i, dat: itr_dat_i,
                    tga: itr_tga_i, tgc: itr_tgc_i, tgd: itr_tgd_i};

  assign any_rst  = async_rst_i | sync_rst_i;
  assign cnt_full = (cnt == {CNT_WIDTH{1'b1}});
  assign rsp      = tgt_ack_i | tgt_err_i | tgt_rty_i;

  // Stall is the registered SKD valid: the initiator is only held off once
  // both entries are occupied, so accept never targets a full buffer.
  assign itr_stall_o = skd_vld;
  assign accept      = itr_cyc_i & itr_stb_i & ~itr_stall_o;

  // A sync clear in progress also blocks issue so nothing is launched from
  // an entry that is about to be discarded.
  assign tgt_stb_o = out_vld & itr_cyc_i & ~cnt_full & ~any_rst;
  assign issue     = tgt_stb_o & ~tgt_stall_i;

  // OUT takes the new request when it is free or emptying this cycle;
  // otherwise the request parks in SKD. SKD refills OUT on issue.
  assign out_load_in  = accept & (~out_vld | issue);
  assign skd_load     = accept & out_vld & ~issue;
  assign out_load_skd = issue & skd_vld;

  always_comb begin
    out_vld_nxt = out_vld;
    skd_vld_nxt = skd_vld;
    cnt_nxt     = cnt;
    if (!itr_cyc_i) begin
      out_vld_nxt = 1'b0;
      skd_vld_nxt = 1'b0;
      cnt_nxt     = '0;
    end else begin
      if (out_load_in || out_load_skd) out_vld_nxt = 1'b1;
      else if (issue)                  out_vld_nxt = 1'b0;
      if (skd_load)          skd_vld_nxt = 1'b1;
      else if (out_load_skd) skd_vld_nxt = 1'b0;
      // Saturating in both directions; issue+response cancels out.
      if (issue && !rsp && !cnt_full)            cnt_nxt = cnt + 1'b1;
      else if (!issue && rsp && (cnt != '0))     cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      out_vld <= 1'b0;
      skd_vld <= 1'b0;
      cnt     <= '0;
    end else if (sync_rst_i) begin
      out_vld <= 1'b0;
      skd_vld <= 1'b0;
      cnt     <= '0;
    end else begin
      out_vld <= out_vld_nxt;
      skd_vld <= skd_vld_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (out_load_in)       out_req <= in_req;
    else if (out_load_skd) out_req <= skd_req;
    if (skd_load)          skd_req <= in_req;
  end

  assign tgt_cyc_o  = itr_cyc_i;
  assign tgt_lock_o = itr_lock_i & itr_cyc_i;
  assign tgt_we_o   = out_req.we;
  assign tgt_sel_o  = out_req.sel;
  assign tgt_adr_o  = out_req.adr;
  assign tgt_dat_o  = out_req.dat;
  assign tgt_tga_o  = out_req.tga;
  assign tgt_tgc_o  = out_req.tgc;
  assign tgt_tgd_o  = out_req.tgd;

`ifdef WBXBC_REQ_SLICE_RSP_FILTER_EN
  // A response with nothing outstanding is a stray; an issue in the same
  // cycle counts as outstanding (zero-wait target).
  assign rsp_pass = (cnt != '0) | issue;
`else
  assign rsp_pass = 1'b1;
`endif

  assign itr_ack_o = tgt_ack_i & itr_cyc_i & rsp_pass;
  assign itr_err_o = tgt_err_i & itr_cyc_i & rsp_pass;
  assign itr_rty_o = tgt_rty_i & itr_cyc_i & rsp_pass;
  assign itr_dat_o = tgt_dat_i;
  assign itr_tgd_o = tgt_tgd_i;

  assign tb_busy = ((cnt != '0) | out_vld | skd_vld) & ~any_rst;

endmodule

// File: tb/tb_wbxbc_req_slice.sv
// Testbench for wbxbc_req_slice: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_wbxbc_req_slice;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic we; logic [1:0] sel; logic [15:0] adr; logic [15:0] dat;
    logic tga; logic tgc; logic tgd;
  } req_t;

  logic clk_i = 0, async_rst_i, sync_rst_i;
  logic itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
  logic [1:0] itr_sel_i; logic [15:0] itr_adr_i, itr_dat_i;
  logic itr_tga_i, itr_tgc_i, itr_tgd_i;
  logic itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
  logic [15:0] itr_dat_o; logic itr_tgd_o;
  logic tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [1:0] tgt_sel_o; logic [15:0] tgt_adr_o, tgt_dat_o;
  logic tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
  logic tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
  logic [15:0] tgt_dat_i; logic tgt_tgd_i;
  logic tb_busy;

  wbxbc_req_slice #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
    .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i), .itr_lock_i(itr_lock_i),
    .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i), .itr_dat_i(itr_dat_i),
    .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i), .itr_tgd_i(itr_tgd_i),
    .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o),
    .itr_dat_o(itr_dat_o), .itr_tgd_o(itr_tgd_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o),
    .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
    .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o),
    .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
    .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i), .tb_busy(tb_busy)
  );

  always #5 clk_i = ~clk_i;

  int errs = 0, checks = 0;
  req_t q[$];      // requests held in the slice, oldest first
  int   cnt_m = 0; // issued but unanswered requests

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [15:0] adr, input logic [15:0] dat);
    itr_stb_i = 1; itr_we_i = we; itr_adr_i = adr; itr_dat_i = dat;
    itr_sel_i = 2'($urandom); itr_tga_i = 1'($urandom);
    itr_tgc_i = 1'($urandom); itr_tgd_i = 1'($urandom);
  endtask

  task automatic rsp(input logic a, input logic e, input logic r);
    tgt_ack_i = a; tgt_err_i = e; tgt_rty_i = r;
  endtask

  // Check every output against the model for the current inputs, advance
  // the model by one clock, then move to just after the next rising edge.
  task automatic step();
    bit exp_stb, exp_stall, iss, acc, rv, pass;
    req_t cur, obs;
    @(negedge clk_i);
    exp_stall = (q.size() == 2);
    exp_stb   = (q.size() > 0) && itr_cyc_i && (cnt_m < MAXC) && !sync_rst_i && !async_rst_i;
    chk("stall", itr_stall_o, exp_stall);
    chk("tgt_stb", tgt_stb_o, exp_stb);
    chk("busy", tb_busy, ((cnt_m != 0) || (q.size() > 0)) && !sync_rst_i && !async_rst_i);
    chk("tgt_cyc", tgt_cyc_o, itr_cyc_i);
    chk("tgt_lock", tgt_lock_o, itr_lock_i & itr_cyc_i);
    if (exp_stb) begin
      obs = '{tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o};
      chk("payload", obs, q[0]);
    end
    iss = exp_stb && !tgt_stall_i;
    rv  = tgt_ack_i | tgt_err_i | tgt_rty_i;
`ifdef WBXBC_REQ_SLICE_RSP_FILTER_EN
    pass = (cnt_m != 0) || iss;
`else
    pass = 1;
`endif
    chk("ack", itr_ack_o, tgt_ack_i & itr_cyc_i & pass);
    chk("err", itr_err_o, tgt_err_i & itr_cyc_i & pass);
    chk("rty", itr_rty_o, tgt_rty_i & itr_cyc_i & pass);
    chk("rdat", {itr_tgd_o, itr_dat_o}, {tgt_tgd_i, tgt_dat_i});
    acc = itr_cyc_i && itr_stb_i && !exp_stall;
    cur = '{itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};
    if (sync_rst_i || async_rst_i || !itr_cyc_i) begin
      q.delete(); cnt_m = 0;
    end else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(cur);
      if (iss && !rv) cnt_m++;
      else if (!iss && rv && cnt_m > 0) cnt_m--;
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    async_rst_i = 1; sync_rst_i = 0;
    itr_cyc_i = 0; itr_stb_i = 0; itr_we_i = 0; itr_lock_i = 0;
    itr_sel_i = 0; itr_adr_i = 0; itr_dat_i = 0; itr_tga_i = 0; itr_tgc_i = 0; itr_tgd_i = 0;
    rsp(0, 0, 0); tgt_stall_i = 0; tgt_dat_i = 16'hA5A5; tgt_tgd_i = 1;
    #2;
    chk("rst_stb", tgt_stb_o, 0);
    chk("rst_stall", itr_stall_o, 0);
    chk("rst_busy", tb_busy, 0);
    @(posedge clk_i); #1;
    async_rst_i = 0; itr_cyc_i = 1;
    step();

    // Single write, immediate issue and ack.
    set_req(1, 16'h1234, 16'hBEEF); step();
    itr_stb_i = 0; step();                       // issued
    chk("w1_busy", tb_busy, 1);
    rsp(1, 0, 0); step(); rsp(0, 0, 0);
    step();
    chk("w1_idle", tb_busy, 0);

    // Three back-to-back reads against a stalled target.
    tgt_stall_i = 1;
    set_req(0, 16'hA000, 0); step();
    set_req(0, 16'hA001, 0); step();
    chk("r3_stall_up", itr_stall_o, 1);
    set_req(0, 16'hA002, 0); step();
    tgt_stall_i = 0; step();                     // A0 issues
    step();                                      // A1 issues, A2 accepted
    itr_stb_i = 0; step();                       // A2 issues
    chk("r3_drained", q.size(), 0);
    rsp(1, 0, 0); step(); step(); step(); rsp(0, 0, 0);
    step();

    // Counter saturation: no acks, four writes.
    for (int i = 0; i < 4; i++) begin set_req(1, 16'h0B00 + 16'(i), 16'(i)); step(); end
    itr_stb_i = 0; step();
    chk("full_stb", tgt_stb_o, 0);
    chk("full_q", q.size(), 1);
    rsp(1, 0, 0); step(); rsp(0, 0, 0);
    chk("full_resume", tgt_stb_o, 1);
    step();
    rsp(0, 1, 0); step(); rsp(0, 0, 1); step(); rsp(1, 0, 0); step(); rsp(0, 0, 0);
    step();

    // Abort with both entries full.
    tgt_stall_i = 1;
    set_req(1, 16'hC000, 1); step();
    set_req(1, 16'hC001, 2); step();
    itr_stb_i = 0; itr_cyc_i = 0; step();
    chk("abort_stall", itr_stall_o, 0);
    chk("abort_stb", tgt_stb_o, 0);
    itr_cyc_i = 1; tgt_stall_i = 0; step();
    chk("abort_busy", tb_busy, 0);

    // Stray ack with nothing outstanding.
    rsp(1, 0, 0); step(); rsp(0, 0, 0);

    // Async reset mid-burst.
    tgt_stall_i = 1;
    set_req(0, 16'hD000, 0); step();
    set_req(0, 16'hD001, 0); step();
    async_rst_i = 1; #2;
    chk("arst_busy", tb_busy, 0);
    chk("arst_stb", tgt_stb_o, 0);
    rsp(1, 0, 0); #1;
    chk("arst_rsp_pass", itr_dat_o, tgt_dat_i);
    async_rst_i = 0; q.delete(); cnt_m = 0;
    itr_stb_i = 0; rsp(0, 0, 0); tgt_stall_i = 0;
    @(posedge clk_i); #1;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      itr_cyc_i   = ($urandom_range(0, 99) >= 3);
      sync_rst_i  = ($urandom_range(0, 99) < 2);
      itr_lock_i  = 1'($urandom);
      tgt_stall_i = ($urandom_range(0, 99) < 30);
      tgt_dat_i   = 16'($urandom); tgt_tgd_i = 1'($urandom);
      if ($urandom_range(0, 99) < 70) set_req(1'($urandom), 16'($urandom), 16'($urandom));
      else itr_stb_i = 0;
      case ($urandom_range(0, 9))
        0, 1, 2: rsp(1, 0, 0);
        3:       rsp(0, 1, 0);
        4:       rsp(0, 0, 1);
        default: rsp(0, 0, 0);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
